cavlc_block_stats: RTL

// - Parametrised CAVLC statistics engine: takes one residual block in zigzag order and

---
 rtl/cavlc_pkg.sv | 31 +++
 rtl/cavlc_scan_lane.sv | 74 +++++++
 rtl/cavlc_block_stats.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cavlc_pkg.sv
// Shared types and helpers for the CAVLC block statistics engine.
package cavlc_pkg;

    typedef enum logic [1:0] {
        MODE_LUMA16     = 2'd0,
        MODE_AC15       = 2'd1,
        MODE_CDC4       = 2'd2,
        MODE_LUMA16_ALT = 2'd3
    } blk_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a counter able to hold 0..max_coeff.
    function automatic int unsigned cnt_w(input int unsigned max_coeff);
        return $clog2(max_coeff + 1);
    endfunction

    // Slot participation per block mode; inactive slots are ignored entirely.
    function automatic logic slot_active(input blk_mode_e mode, input int unsigned idx);
        case (mode)
            MODE_AC15: return (idx >= 32'd1);
            MODE_CDC4: return (idx < 32'd4);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cavlc_scan_lane.sv
// One coefficient-slot step of the high-to-low scan: nonzero count,
// trailing-one detection, zero/run tracking and list-write strobes.
module cavlc_scan_lane #(
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic               active,
    input  logic [COEFF_W-1:0] coeff,
    input  logic [CNT_W-1:0]   tc_cur,
    input  logic [1:0]         t1_cur,
    input  logic [2:0]         sgn_cur,
    input  logic               t1_done_cur,
    input  logic               seen_cur,
    input  logic [CNT_W-1:0]   tz_cur,
    input  logic [CNT_W-1:0]   run_cur,
    input  logic [CNT_W-1:0]   lvl_cnt_cur,
    input  logic [CNT_W-1:0]   run_cnt_cur,
    output logic [CNT_W-1:0]   tc_nxt,
    output logic [1:0]         t1_nxt,
    output logic [2:0]         sgn_nxt,
    output logic               t1_done_nxt,
    output logic               seen_nxt,
    output logic [CNT_W-1:0]   tz_nxt,
    output logic [CNT_W-1:0]   run_nxt,
    output logic [CNT_W-1:0]   lvl_cnt_nxt,
    output logic [CNT_W-1:0]   run_cnt_nxt,
    output logic               lvl_we,
    output logic               run_we
);

    logic nz;
    logic mag_one;

    assign nz      = (coeff != '0);
    assign mag_one = (coeff == COEFF_W'(1)) || (coeff == '1);

    // Slot update: a nonzero either extends the trailing-one run or becomes a level.
    always_comb begin
        tc_nxt      = tc_cur;
        t1_nxt      = t1_cur;
        sgn_nxt     = sgn_cur;
        t1_done_nxt = t1_done_cur;
        seen_nxt    = seen_cur;
        tz_nxt      = tz_cur;
        run_nxt     = run_cur;
        lvl_cnt_nxt = lvl_cnt_cur;
        run_cnt_nxt = run_cnt_cur;
        lvl_we      = 1'b0;
        run_we      = 1'b0;
        if (active) begin
            if (nz) begin
                tc_nxt   = tc_cur + CNT_W'(1);
                seen_nxt = 1'b1;
                run_nxt  = '0;
                if (seen_cur) begin
                    run_we      = 1'b1;
                    run_cnt_nxt = run_cnt_cur + CNT_W'(1);
                end
                if (!t1_done_cur && mag_one && (t1_cur != 2'd3)) begin
                    t1_nxt           = t1_cur + 2'd1;
                    sgn_nxt[t1_cur]  = coeff[COEFF_W-1];
                end else begin
                    lvl_we      = 1'b1;
                    lvl_cnt_nxt = lvl_cnt_cur + CNT_W'(1);
                    t1_done_nxt = 1'b1;
                end
            end else if (seen_cur) begin
                tz_nxt  = tz_cur + CNT_W'(1);
                run_nxt = run_cur + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cavlc_block_stats.sv
// CAVLC statistics engine: scans one zigzag residual block LANES slots per
// cycle and reports TotalCoeff, trailing ones, TotalZeros, levels and runs.
module cavlc_block_stats
    import cavlc_pkg::*;
#(
    parameter  int unsigned COEFF_W   = 16,
    parameter  int unsigned MAX_COEFF = 16,
    parameter  int unsigned LANES     = 1,
    parameter  int unsigned TAG_W     = 20,
    localparam int unsigned CNT_W     = cnt_w(MAX_COEFF)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   blk_mode,
    input  logic [TAG_W-1:0]             tag_i,
    input  logic [MAX_COEFF*COEFF_W-1:0] coeff_i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TAG_W-1:0]             tag_o,
    output logic [CNT_W-1:0]             total_coeff,
    output logic [1:0]                   trailing_ones,
    output logic [2:0]                   t1_signs,
    output logic [CNT_W-1:0]             total_zeros,
    output logic [CNT_W-1:0]             level_cnt,
    output logic [MAX_COEFF*COEFF_W-1:0] level_list,
    output logic [CNT_W-1:0]             run_cnt,
    output logic [MAX_COEFF*CNT_W-1:0]   run_list
);

    localparam int unsigned NGRP  = MAX_COEFF / LANES;
    localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned IDX_W = $clog2(MAX_COEFF);

    state_e             state_q, state_nxt;
    blk_mode_e          mode_q;
    logic [TAG_W-1:0]   tag_q;
    logic [COEFF_W-1:0] coeff_q [MAX_COEFF];
    logic [GRP_W-1:0]   grp_q;
    logic               accept;

    logic [CNT_W-1:0]   tc_q, tz_q, run_q, lvl_cnt_q, run_cnt_q;
    logic [1:0]         t1_q;
    logic [2:0]         sgn_q;
    logic               t1_done_q, seen_q;
    logic [COEFF_W-1:0] lvl_list_q [MAX_COEFF];
    logic [CNT_W-1:0]   run_list_q [MAX_COEFF];

    logic [CNT_W-1:0]   tc_ch      [LANES+1];
    logic [1:0]         t1_ch      [LANES+1];
    logic [2:0]         sgn_ch     [LANES+1];
    logic               t1_done_ch [LANES+1];
    logic               seen_ch    [LANES+1];
    logic [CNT_W-1:0]   tz_ch      [LANES+1];
    logic [CNT_W-1:0]   run_ch     [LANES+1];
    logic [CNT_W-1:0]   lvl_cnt_ch [LANES+1];
    logic [CNT_W-1:0]   run_cnt_ch [LANES+1];

    logic [IDX_W-1:0]   slot_idx   [LANES];
    logic [COEFF_W-1:0] lane_coeff [LANES];
    logic               lane_act   [LANES];
    logic               lvl_we     [LANES];
    logic               run_we     [LANES];

    assign accept = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    // Next-state: fixed-length scan, back-to-back accept straight from DONE.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_nxt = ST_SCAN;
            ST_SCAN: if (grp_q == '0) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = in_valid ? ST_SCAN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
    end

    assign tc_ch[0]      = tc_q;
    assign t1_ch[0]      = t1_q;
    assign sgn_ch[0]     = sgn_q;
    assign t1_done_ch[0] = t1_done_q;
    assign seen_ch[0]    = seen_q;
    assign tz_ch[0]      = tz_q;
    assign run_ch[0]     = run_q;
    assign lvl_cnt_ch[0] = lvl_cnt_q;
    assign run_cnt_ch[0] = run_cnt_q;

    // Lane 0 takes the highest slot of the current group.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int unsigned OFF = LANES - 1 - l;
        assign slot_idx[l]   = IDX_W'(32'(grp_q) * LANES + OFF);
        assign lane_coeff[l] = coeff_q[slot_idx[l]];
        assign lane_act[l]   = slot_active(mode_q, 32'(slot_idx[l]));

        cavlc_scan_lane #(
            .COEFF_W (COEFF_W),
            .CNT_W   (CNT_W)
        ) u_lane (
            .active      (lane_act[l]),
            .coeff       (lane_coeff[l]),
            .tc_cur      (tc_ch[l]),
            .t1_cur      (t1_ch[l]),
            .sgn_cur     (sgn_ch[l]),
            .t1_done_cur (t1_done_ch[l]),
            .seen_cur    (seen_ch[l]),
            .tz_cur      (tz_ch[l]),
            .run_cur     (run_ch[l]),
            .lvl_cnt_cur (lvl_cnt_ch[l]),
            .run_cnt_cur (run_cnt_ch[l]),
            .tc_nxt      (tc_ch[l+1]),
            .t1_nxt      (t1_ch[l+1]),
            .sgn_nxt     (sgn_ch[l+1]),
            .t1_done_nxt (t1_done_ch[l+1]),
            .seen_nxt    (seen_ch[l+1]),
            .tz_nxt      (tz_ch[l+1]),
            .run_nxt     (run_ch[l+1]),
            .lvl_cnt_nxt (lvl_cnt_ch[l+1]),
            .run_cnt_nxt (run_cnt_ch[l+1]),
            .lvl_we      (lvl_we[l]),
            .run_we      (run_we[l])
        );
    end

    // Block register, running statistics and list storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_LUMA16;
            tag_q     <= '0;
            grp_q     <= '0;
            tc_q      <= '0;
            t1_q      <= '0;
            sgn_q     <= '0;
            t1_done_q <= 1'b0;
            seen_q    <= 1'b0;
            tz_q      <= '0;
            run_q     <= '0;
            lvl_cnt_q <= '0;
            run_cnt_q <= '0;
            for (int k = 0; k < MAX_COEFF; k++) begin
                coeff_q[k]    <= '0;
                lvl_list_q[k] <= '0;
                run_list_q[k] <= '0;
            end
        end else if (accept) begin
            mode_q    <= blk_mode_e'(blk_mode);
            tag_q     <= tag_i;
            grp_q     <= GRP_W'(NGRP - 1);
            tc_q      <= '0;
            t1_q      <= '0;
            sgn_q     <= '0;
            t1_done_q <= 1'b0;
            seen_q    <= 1'b0;
            tz_q      <= '0;
            run_q     <= '0;
            lvl_cnt_q <= '0;
            run_cnt_q <= '0;
            for (int k = 0; k < MAX_COEFF; k++) begin
                coeff_q[k]    <= coeff_i[k*COEFF_W +: COEFF_W];
                lvl_list_q[k] <= '0;
                run_list_q[k] <= '0;
            end
        end else if (state_q == ST_SCAN) begin
            grp_q     <= grp_q - GRP_W'(1);
            tc_q      <= tc_ch[LANES];
            t1_q      <= t1_ch[LANES];
            sgn_q     <= sgn_ch[LANES];
            t1_done_q <= t1_done_ch[LANES];
            seen_q    <= seen_ch[LANES];
            tz_q      <= tz_ch[LANES];
            run_q     <= run_ch[LANES];
            lvl_cnt_q <= lvl_cnt_ch[LANES];
            run_cnt_q <= run_cnt_ch[LANES];
            for (int l = 0; l < LANES; l++) begin
                if (lvl_we[l]) lvl_list_q[IDX_W'(lvl_cnt_ch[l])] <= lane_coeff[l];
                if (run_we[l]) run_list_q[IDX_W'(run_cnt_ch[l])] <= run_ch[l];
            end
        end
    end

    assign tag_o         = tag_q;
    assign total_coeff   = tc_q;
    assign trailing_ones = t1_q;
    assign t1_signs      = sgn_q;
    assign total_zeros   = tz_q;
    assign level_cnt     = lvl_cnt_q;
    assign run_cnt       = run_cnt_q;

    // Flatten list registers onto the output buses.
    for (genvar k = 0; k < MAX_COEFF; k++) begin : g_flat
        assign level_list[k*COEFF_W +: COEFF_W] = lvl_list_q[k];
        assign run_list[k*CNT_W +: CNT_W]       = run_list_q[k];
    end

endmodule
